// File: rtl/vec_pkg.sv
// Shared types and constants for the vector issue sequencer slice.
// VEC_SEQ_TAIL_UNDISTURBED_EN enables the per-element tail mask helper.
package vec_pkg;
  localparam int unsigned VLEN          = 128;
  localparam int unsigned ELEN          = 32;
  localparam int unsigned NUM_VEC_LANES = VLEN / ELEN;
  localparam int unsigned VLMAX         = 16;
  localparam int unsigned NUM_VEC_REGS  = 32;
  localparam int unsigned MAX_BEATS     = VLMAX / NUM_VEC_LANES;

  typedef enum logic [3:0] {
    VOP_ADD = 4'd0,
    VOP_SUB = 4'd1,
    VOP_AND = 4'd2,
    VOP_OR  = 4'd3,
    VOP_XOR = 4'd4,
    VOP_SLL = 4'd5,
    VOP_SRL = 4'd6,
    VOP_MUL = 4'd7
  } vec_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } seq_state_e;

  typedef struct packed {
    logic [4:0]               addr;
    logic [NUM_VEC_LANES-1:0] mask;
  } wb_tag_t;

`ifdef VEC_SEQ_TAIL_UNDISTURBED_EN
  // Lane i is live while fewer than 'remaining' elements precede it in the beat.
  function automatic logic [NUM_VEC_LANES-1:0] tail_mask(input logic [4:0] remaining);
    logic [NUM_VEC_LANES-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < NUM_VEC_LANES; i++) begin
      m[i] = (5'(i) < remaining);
    end
    return m;
  endfunction
`endif
endpackage

// File: rtl/vec_wb_tag_fifo.sv
// Two-entry FIFO of writeback tags; a push into a full FIFO is taken when a pop
// frees a slot in the same cycle.
module vec_wb_tag_fifo
  import vec_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  wb_tag_t push_tag,
  input  logic    pop,
  output wb_tag_t pop_tag,
  output logic    empty,
  output logic    full
);
  wb_tag_t    mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       do_push;
  logic       do_pop;

  assign empty   = (count == 2'd0);
  assign full    = (count == 2'd2);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign pop_tag = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 2; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_tag;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end
endmodule

// File: rtl/vector_issue_sequencer.sv
// Strip-mining sequencer: splits one vector instruction into VLEN-wide beats for
// the 1-cycle EU and writes results back. Macro: VEC_SEQ_TAIL_UNDISTURBED_EN.
module vector_issue_sequencer
  import vec_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     instr_valid,
  output logic                     instr_ready,
  input  logic [3:0]               instr_op,
  input  logic [4:0]               instr_vs1,
  input  logic [4:0]               instr_vs2,
  input  logic [4:0]               instr_vd,
  input  logic [31:0]              instr_vl,
  output logic [4:0]               vreg_rd_addr1,
  output logic [4:0]               vreg_rd_addr2,
  input  logic [VLEN-1:0]          vreg_rd_data1,
  input  logic [VLEN-1:0]          vreg_rd_data2,
  output logic [VLEN-1:0]          eu_src1,
  output logic [VLEN-1:0]          eu_src2,
  output logic [3:0]               eu_op,
  output logic                     eu_valid,
  input  logic [VLEN-1:0]          eu_result,
  input  logic                     eu_result_valid,
  output logic [4:0]               vreg_wr_addr,
  output logic [VLEN-1:0]          vreg_wr_data,
  output logic [NUM_VEC_LANES-1:0] vreg_wr_be,
  output logic                     vreg_wr_en,
  output logic                     busy,
  output logic                     done
);
  localparam int unsigned BEAT_W = $clog2(MAX_BEATS);
  localparam int unsigned NB_W   = BEAT_W + 1;

  seq_state_e        state;
  logic [3:0]        op_q;
  logic [4:0]        vs1_q;
  logic [4:0]        vs2_q;
  logic [4:0]        vd_q;
`ifdef VEC_SEQ_TAIL_UNDISTURBED_EN
  logic [4:0]        vl_q;
`endif
  logic [NB_W-1:0]   nbeats_q;
  logic [BEAT_W-1:0] beat_q;
  logic [1:0]        outstanding;

  logic [4:0]        vl_eff;
  logic [NB_W-1:0]   nbeats_in;
  logic              accept;
  logic              issuing;
  logic              last_beat;
  logic              pop;
  logic              final_pop;
  logic              fifo_push;
  logic              fifo_empty;
  logic              fifo_full;
  wb_tag_t           push_tag;
  wb_tag_t           pop_tag;

  always_comb begin
    vl_eff    = (instr_vl > 32'(VLMAX)) ? 5'(VLMAX) : instr_vl[4:0];
    nbeats_in = NB_W'((32'(vl_eff) + NUM_VEC_LANES - 1) / NUM_VEC_LANES);
  end

  assign instr_ready = (state == IDLE);
  assign busy        = (state != IDLE);
  assign accept      = instr_valid && instr_ready;
  assign issuing     = (state == ISSUE);
  assign last_beat   = issuing && (beat_q == BEAT_W'(nbeats_q - 1'b1));

  assign vreg_rd_addr1 = issuing ? vs1_q + 5'(beat_q) : '0;
  assign vreg_rd_addr2 = issuing ? vs2_q + 5'(beat_q) : '0;
  assign eu_src1       = issuing ? vreg_rd_data1 : '0;
  assign eu_src2       = issuing ? vreg_rd_data2 : '0;
  assign eu_op         = issuing ? op_q : '0;
  assign eu_valid      = issuing;

  always_comb begin
    push_tag      = '0;
    push_tag.addr = vd_q + 5'(beat_q);
`ifdef VEC_SEQ_TAIL_UNDISTURBED_EN
    push_tag.mask = tail_mask(vl_q - 5'(32'(beat_q) * NUM_VEC_LANES));
`else
    push_tag.mask = '1;
`endif
  end

  assign fifo_push = issuing && (!fifo_full || pop);
  assign pop       = eu_result_valid && !fifo_empty;
  // Only the last result can drain the counter to zero while in DRAIN.
  assign final_pop = pop && (state == DRAIN) && (outstanding == 2'd1);

  vec_wb_tag_fifo u_tag_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (fifo_push),
    .push_tag (push_tag),
    .pop      (pop),
    .pop_tag  (pop_tag),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      op_q         <= '0;
      vs1_q        <= '0;
      vs2_q        <= '0;
      vd_q         <= '0;
`ifdef VEC_SEQ_TAIL_UNDISTURBED_EN
      vl_q         <= '0;
`endif
      nbeats_q     <= '0;
      beat_q       <= '0;
      outstanding  <= '0;
      vreg_wr_en   <= 1'b0;
      vreg_wr_addr <= '0;
      vreg_wr_data <= '0;
      vreg_wr_be   <= '0;
      done         <= 1'b0;
    end else begin
      done        <= 1'b0;
      vreg_wr_en  <= pop;
      outstanding <= outstanding + {1'b0, fifo_push} - {1'b0, pop};
      if (pop) begin
        vreg_wr_addr <= pop_tag.addr;
        vreg_wr_data <= eu_result;
        vreg_wr_be   <= pop_tag.mask;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            op_q     <= instr_op;
            vs1_q    <= instr_vs1;
            vs2_q    <= instr_vs2;
            vd_q     <= instr_vd;
`ifdef VEC_SEQ_TAIL_UNDISTURBED_EN
            vl_q     <= vl_eff;
`endif
            nbeats_q <= nbeats_in;
            beat_q   <= '0;
            if (vl_eff == '0) begin
              done <= 1'b1;
            end else begin
              state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          beat_q <= beat_q + 1'b1;
          if (last_beat) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (final_pop) begin
            done <= 1'b1;
          end
          if (done) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
